// File: rtl/fwvip_wb_targ_mem.sv
// Wishbone B4 classic target backed by a word-addressed RAM with programmable wait states.
// Define FWVIP_WB_TARG_MEM_ERR_EN to return err for addresses beyond the RAM.
`timescale 1ns/1ps
module fwvip_wb_targ_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat_w,
    output logic [DATA_WIDTH-1:0]   dat_r,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    output logic                    ack,
    output logic                    err,
    output logic [15:0]             txn_count
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int AB  = $clog2(SW);
    localparam int TOP = AB + DEPTH_LOG2;
    localparam logic [7:0] WS = 8'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    we_q, we_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic                    bad_q, bad_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [15:0]             txn_q, txn_d;
    logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];
    logic                    done;
    logic                    bad_now;
    logic                    unused_adr;

`ifdef FWVIP_WB_TARG_MEM_ERR_EN
    assign bad_now    = |adr[ADDR_WIDTH-1:TOP];
    assign unused_adr = &{1'b0, adr[AB-1:0]};
`else
    // Upper address bits alias into the RAM
    assign bad_now    = 1'b0;
    assign unused_adr = &{1'b0, adr[AB-1:0], adr[ADDR_WIDTH-1:TOP]};
`endif

    // Dropping cyc in RESP is an abort, so the response is gated by cyc
    assign done      = (state_q == RESP) && cyc;
    assign ack       = done && !bad_q;
    assign err       = done && bad_q;
    assign dat_r     = ack ? mem[idx_q] : '0;
    assign txn_count = txn_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        txn_d   = txn_q;
        unique case (state_q)
            IDLE: begin
                if (cyc && stb) begin
                    idx_d   = adr[TOP-1:AB];
                    we_d    = we;
                    sel_d   = sel;
                    wdat_d  = dat_w;
                    bad_d   = bad_now;
                    cnt_d   = 8'd1;
                    state_d = (WS == 8'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= WS) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (cyc) txn_d = txn_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= 8'd0;
            txn_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
        end
    end

    always_ff @(posedge clock) begin
        if (done && we_q && !bad_q) begin
            for (int i = 0; i < SW; i++) begin
                if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_fwvip_wb_targ_mem.sv
// Scoreboard bench for fwvip_wb_targ_mem: model RAM, latency, lanes, abort, err, reset.
`timescale 1ns/1ps
module tb_fwvip_wb_targ_mem;
    localparam int WS = 2;

    typedef struct {
        logic        rd;
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [15:0] txn_count;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] txn_m = 16'd0;
    logic [31:0] mem_m [1024];
    exp_t        sb[$];

    fwvip_wb_targ_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (10),
        .WAIT_STATES(WS)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .adr      (adr),
        .dat_w    (dat_w),
        .dat_r    (dat_r),
        .cyc      (cyc),
        .stb      (stb),
        .we       (we),
        .sel      (sel),
        .ack      (ack),
        .err      (err),
        .txn_count(txn_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        int          n;
        logic        hit;
        logic [9:0]  idx;
        idx      = a[11:2];
        e.rd     = !w;
        e.is_err = 1'b0;
`ifdef FWVIP_WB_TARG_MEM_ERR_EN
        if (a[31:12] != 20'd0) e.is_err = 1'b1;
`endif
        e.data = (w || e.is_err) ? 32'd0 : mem_m[idx];
        sb.push_back(e);
        if (w && !e.is_err) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clock);
        adr = a; dat_w = d; we = w; sel = s;
        cyc = 1'b1; stb = 1'b1;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            @(negedge clock);
            n++;
            hit = ack | err;
        end
        e = sb.pop_front();
        if (!hit) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(n), 32'(1 + WS));
            chk("ack", {31'd0, ack}, {31'd0, !e.is_err});
            chk("err", {31'd0, err}, {31'd0, e.is_err});
            if (e.rd || e.is_err) chk("dat_r", dat_r, e.data);
            @(posedge clock);
            #1;
            txn_m = txn_m + 16'd1;
            chk("pulse", {30'd0, ack, err}, 32'd0);
            chk("txn", {16'd0, txn_count}, {16'd0, txn_m});
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        adr = '0; dat_w = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        repeat (2) @(negedge clock);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_txn", {16'd0, txn_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("txn_two", {16'd0, txn_count}, 32'd2);

        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 32'h23, 32'h00000011, 4'b0001);
        chk("lane_model", mem_m[8], 32'hFFFFFF11);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);
        xfer(1'b1, 32'h20, 32'h12345678, 4'h0);
        xfer(1'b1, 32'h20, 32'hAB00CD00, 4'b1010);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);

        xfer(1'b1, 32'h30, 32'h0BADF00D, 4'hF);
        @(negedge clock);
        adr = 32'h30; dat_w = 32'h12345678; we = 1'b1; sel = 4'hF;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clock);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_rsp", {30'd0, ack, err}, 32'd0);
        end
        chk("abort_txn", {16'd0, txn_count}, {16'd0, txn_m});
        xfer(1'b0, 32'h30, 32'h0, 4'hF);

        xfer(1'b1, 32'h0, 32'h01234567, 4'hF);
        xfer(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF);
        xfer(1'b0, 32'h0, 32'h0, 4'hF);

        for (int i = 0; i < 6; i++)
            xfer(1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
        for (int i = 5; i >= 0; i--)
            xfer(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF);

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            stb = 1'b1; we = 1'b1; adr = 32'h10; dat_w = 32'h0; sel = 4'hF;
            chk("stb_only", {30'd0, ack, err}, 32'd0);
        end
        stb = 1'b0; we = 1'b0;
        chk("stb_txn", {16'd0, txn_count}, {16'd0, txn_m});

        @(negedge clock);
        adr = 32'h40; dat_w = 32'h55AA55AA; we = 1'b1; sel = 4'hF;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_rsp", {30'd0, ack, err}, 32'd0);
        chk("rst_wait_txn", {16'd0, txn_count}, 32'd0);
        txn_m = 16'd0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_after", {30'd0, ack, err}, 32'd0);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
